aes_round_ctrl: RTL

//  Sequencing controller for the AES-128 encryption datapath. Steps the shared SubBytes (SBox)

---
 rtl/aes_round_ctrl_if.sv | 46 ++++
 rtl/aes_round_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the AES round controller and its neighbours.
// The controller uses the slave view; the issuing/consuming side uses the master view.
interface aes_round_ctrl_if;
    logic       start;
    logic       in_ready;
    logic       init_en;
    logic       sub_en;
    logic       key_en;
    logic [7:0] rcon;
    logic       round_en;
    logic       mix_bypass;
    logic [3:0] round_num;
    logic       busy;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output start,
        output out_ready,
        input  in_ready,
        input  init_en,
        input  sub_en,
        input  key_en,
        input  rcon,
        input  round_en,
        input  mix_bypass,
        input  round_num,
        input  busy,
        input  out_valid
    );

    modport slave (
        input  start,
        input  out_ready,
        output in_ready,
        output init_en,
        output sub_en,
        output key_en,
        output rcon,
        output round_en,
        output mix_bypass,
        output round_num,
        output busy,
        output out_valid
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: initial AddRoundKey, NUM_ROUNDS SubBytes/commit rounds, Rcon generation.
// Every control strobe is a register loaded one state ahead, so outputs are glitch-free.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int SBOX_LAT   = 1
) (
    input  logic            clk,
    input  logic            n_rst,
    aes_round_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_SUB    = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [2:0] SUB_LAST   = 3'(SBOX_LAT - 1);

    // GF(2^8) doubling with the AES reduction polynomial.
    function automatic logic [7:0] rcon_next(input logic [7:0] rc);
        return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
    endfunction

    state_t     r_state;
    logic [2:0] r_wait_cnt;
    logic [3:0] r_round_num;
    logic [7:0] r_rcon;
    logic       r_idle;
    logic       r_init_en;
    logic       r_sub_en;
    logic       r_key_en;
    logic       r_round_en;
    logic       r_mix_bypass;
    logic       r_busy;
    logic       r_out_valid;
    logic       w_in_ready;

    // A finished block being drained this cycle frees the controller for a back-to-back start.
    assign w_in_ready     = r_idle | (r_out_valid & bus.out_ready);
    assign bus.in_ready   = w_in_ready;
    assign bus.init_en    = r_init_en;
    assign bus.sub_en     = r_sub_en;
    assign bus.key_en     = r_key_en;
    assign bus.rcon       = r_rcon;
    assign bus.round_en   = r_round_en;
    assign bus.mix_bypass = r_mix_bypass;
    assign bus.round_num  = r_round_num;
    assign bus.busy       = r_busy;
    assign bus.out_valid  = r_out_valid;

    // Sequencer state, counters and registered control strobes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 3'd0;
            r_round_num  <= 4'd0;
            r_rcon       <= 8'h01;
            r_idle       <= 1'b1;
            r_init_en    <= 1'b0;
            r_sub_en     <= 1'b0;
            r_key_en     <= 1'b0;
            r_round_en   <= 1'b0;
            r_mix_bypass <= 1'b0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_init_en    <= 1'b0;
            r_sub_en     <= 1'b0;
            r_key_en     <= 1'b0;
            r_round_en   <= 1'b0;
            r_mix_bypass <= 1'b0;
            if (r_key_en) begin
                r_rcon <= rcon_next(r_rcon);
            end else begin
                r_rcon <= r_rcon;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state     <= S_INIT;
                        r_idle      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_init_en   <= 1'b1;
                        r_rcon      <= 8'h01;
                        r_round_num <= 4'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_INIT: begin
                    r_state     <= S_SUB;
                    r_round_num <= 4'd1;
                    r_sub_en    <= 1'b1;
                    r_key_en    <= 1'b1;
                    r_wait_cnt  <= 3'd0;
                end
                S_SUB: begin
                    if (r_wait_cnt == SUB_LAST) begin
                        r_state      <= S_COMMIT;
                        r_round_en   <= 1'b1;
                        r_mix_bypass <= (r_round_num == LAST_ROUND);
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 3'd1;
                    end
                end
                S_COMMIT: begin
                    if (r_round_num < LAST_ROUND) begin
                        r_state     <= S_SUB;
                        r_round_num <= r_round_num + 4'd1;
                        r_sub_en    <= 1'b1;
                        r_key_en    <= 1'b1;
                        r_wait_cnt  <= 3'd0;
                    end else begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (bus.start) begin
                            r_state     <= S_INIT;
                            r_busy      <= 1'b1;
                            r_init_en   <= 1'b1;
                            r_rcon      <= 8'h01;
                            r_round_num <= 4'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_idle  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_idle      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_round_num <= 4'd0;
                end
            endcase
        end
    end

endmodule
